// File: rtl/vertex_transform_sequencer_if.sv
// ---------------------------------------------------------------------------
// vertex_transform_sequencer_if
// Bundles every non-clock/reset signal of the vertex transform sequencer:
// the matrix load port, the input vertex stream, the matrixVectorMultiply
// start/busy/done interface and the output vertex stream.
//   master : the sequencer (drives ready/start/operands/result/status)
//   slave  : its environment (vertex fetch, multiplier, rasteriser)
// Elements are WIDTH-bit signed fixed point; index [0] is x / row 0.
// ---------------------------------------------------------------------------
interface vertex_transform_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [3:0][3:0][WIDTH-1:0] matrix_in;
  logic                       matrix_load;
  logic [3:0][WIDTH-1:0]      vtx_in;
  logic                       vtx_in_valid;
  logic                       vtx_in_ready;
  logic                       mvm_start;
  logic [3:0][3:0][WIDTH-1:0] mvm_m1;
  logic [3:0][WIDTH-1:0]      mvm_v1;
  logic [3:0][WIDTH-1:0]      mvm_v_out;
  logic                       mvm_busy;
  logic                       mvm_done;
  logic [3:0][WIDTH-1:0]      vtx_out;
  logic                       vtx_out_valid;
  logic                       vtx_out_ready;
  logic                       busy;
  logic                       timeout_err;

  modport master (
    input  matrix_in, matrix_load, vtx_in, vtx_in_valid,
           mvm_v_out, mvm_busy, mvm_done, vtx_out_ready,
    output vtx_in_ready, mvm_start, mvm_m1, mvm_v1,
           vtx_out, vtx_out_valid, busy, timeout_err
  );

  modport slave (
    output matrix_in, matrix_load, vtx_in, vtx_in_valid,
           mvm_v_out, mvm_busy, mvm_done, vtx_out_ready,
    input  vtx_in_ready, mvm_start, mvm_m1, mvm_v1,
           vtx_out, vtx_out_valid, busy, timeout_err
  );
endinterface

// File: rtl/vertex_transform_sequencer.sv
// ---------------------------------------------------------------------------
// vertex_transform_sequencer
// Initiator for a matrixVectorMultiply unit. Accepts one homogeneous vertex
// at a time, issues a single multiply against the active 4x4 matrix, captures
// the result on done and offers it downstream. Values pass through bit-exact.
// A watchdog aborts a multiply that never returns done (sticky timeout_err).
//
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   bus (master)   : matrix load, vertex in/out streams, multiplier
//                    start/busy/done, busy and timeout_err status
//   perf_vtx_count, perf_stall_cycles (only with XFORM_SEQ_PERF_CNT_EN):
//                    output handshakes / cycles stalled in OUT, wrap at 2^32
//
// Configuration macro: XFORM_SEQ_PERF_CNT_EN (adds the perf counters).
// Parameters: WIDTH (element width), TIMEOUT_CYCLES (>=2, WAIT budget).
// ---------------------------------------------------------------------------
module vertex_transform_sequencer #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  vertex_transform_sequencer_if.master  bus
`ifdef XFORM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_vtx_count,
  output logic [31:0]                   perf_stall_cycles
`endif
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                     state_q;
  logic [3:0][3:0][WIDTH-1:0] active_q;
  logic [3:0][3:0][WIDTH-1:0] shadow_q;
  logic                       load_pend_q;
  logic [3:0][WIDTH-1:0]      vin_q;
  logic [3:0][WIDTH-1:0]      vout_q;
  logic [WD_W-1:0]            wdog_q;
  logic                       timeout_err_q;
`ifdef XFORM_SEQ_PERF_CNT_EN
  logic [31:0]                perf_vtx_q;
  logic [31:0]                perf_stall_q;
`endif

  // Ready is blocked while a matrix update is pending or arriving this
  // cycle, so an accepted vertex always sees a fully committed matrix.
  logic in_ready;
  assign in_ready = (state_q == S_IDLE) && !load_pend_q && !bus.matrix_load;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      active_q      <= '0;
      shadow_q      <= '0;
      load_pend_q   <= 1'b0;
      vin_q         <= '0;
      vout_q        <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
`ifdef XFORM_SEQ_PERF_CNT_EN
      perf_vtx_q    <= '0;
      perf_stall_q  <= '0;
`endif
    end else begin
      // A load may arrive in any state; it only reaches the active matrix
      // from IDLE, so an in-flight vertex keeps the matrix it started with.
      if (bus.matrix_load) begin
        shadow_q    <= bus.matrix_in;
        load_pend_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (load_pend_q) begin
            active_q <= shadow_q;
            // A fresh load in the same cycle keeps the pending flag so the
            // newer shadow gets committed next cycle.
            if (!bus.matrix_load) load_pend_q <= 1'b0;
          end else if (bus.vtx_in_valid && in_ready) begin
            vin_q   <= bus.vtx_in;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!bus.mvm_busy) begin
            wdog_q  <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // done has priority over a coincident watchdog expiry
          if (bus.mvm_done) begin
            vout_q  <= bus.mvm_v_out;
            state_q <= S_OUT;
          end else if (wdog_q == WD_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.vtx_out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

`ifdef XFORM_SEQ_PERF_CNT_EN
      if (state_q == S_OUT) begin
        if (bus.vtx_out_ready) perf_vtx_q   <= perf_vtx_q + 32'd1;
        else                   perf_stall_q <= perf_stall_q + 32'd1;
      end
`endif
    end
  end

  assign bus.vtx_in_ready  = in_ready;
  // start depends on the live busy input so the request is never issued
  // into a multiplier that is still occupied
  assign bus.mvm_start     = (state_q == S_ISSUE) && !bus.mvm_busy;
  assign bus.mvm_m1        = active_q;
  assign bus.mvm_v1        = vin_q;
  assign bus.vtx_out       = vout_q;
  assign bus.vtx_out_valid = (state_q == S_OUT);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.timeout_err   = timeout_err_q;

`ifdef XFORM_SEQ_PERF_CNT_EN
  assign perf_vtx_count    = perf_vtx_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_vertex_transform_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vertex_transform_sequencer
// Directed bench with a behavioural Q16.16 multiplier model of programmable
// latency. Table-driven transform vectors plus hand-written sequences for
// output stall, matrix load during WAIT, watchdog timeout and reset mid-WAIT.
// ---------------------------------------------------------------------------
module tb_vertex_transform_sequencer;

  typedef logic [3:0][31:0]      vtx_t;
  typedef logic [3:0][3:0][31:0] mat_t;

  typedef struct {
    mat_t m;
    vtx_t v;
    int   lat;
    vtx_t exp;
  } rec_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  vertex_transform_sequencer_if #(.WIDTH(32)) bus ();

`ifdef XFORM_SEQ_PERF_CNT_EN
  logic [31:0] perf_vtx_count;
  logic [31:0] perf_stall_cycles;
`endif

  vertex_transform_sequencer #(.WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .bus               (bus)
`ifdef XFORM_SEQ_PERF_CNT_EN
    ,
    .perf_vtx_count    (perf_vtx_count),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  // ---------------- multiplier model ----------------
  int   lat         = 5;
  bit   never_done  = 1'b0;
  bit   force_busy  = 1'b0;
  bit   inject_done = 1'b0;
  logic m_busy_q    = 1'b0;
  logic m_done_q    = 1'b0;
  int   m_cnt_q     = 0;
  vtx_t m_res_q     = '0;
  vtx_t m_out_q     = '0;

  function automatic vtx_t mvm_model(input mat_t m, input vtx_t v);
    vtx_t r;
    for (int i = 0; i < 4; i++) begin
      longint acc = 0;
      for (int j = 0; j < 4; j++)
        acc += longint'($signed(m[i][j])) * longint'($signed(v[j]));
      r[i] = 32'(acc >>> 16);
    end
    return r;
  endfunction

  always @(posedge clk_in) begin
    m_done_q <= inject_done;
    if (m_busy_q) begin
      if (m_cnt_q <= 1) begin
        m_busy_q <= 1'b0;
        if (!never_done) begin
          m_done_q <= 1'b1;
          m_out_q  <= m_res_q;
        end
      end else begin
        m_cnt_q <= m_cnt_q - 1;
      end
    end else if (bus.mvm_start) begin
      m_res_q  <= mvm_model(bus.mvm_m1, bus.mvm_v1);
      m_cnt_q  <= lat;
      m_busy_q <= 1'b1;
    end
  end

  assign bus.mvm_busy  = m_busy_q | force_busy;
  assign bus.mvm_done  = m_done_q;
  assign bus.mvm_v_out = m_out_q;

  // ---------------- check helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input vtx_t act, input vtx_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkm(input string name, input mat_t act, input mat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vtx_t mk_vtx(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic mat_t mk_mat(input vtx_t r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  // Load a matrix from IDLE: ready low on the load cycle and the commit cycle.
  task automatic load_matrix(input mat_t m);
    @(negedge clk_in);
    bus.matrix_in   = m;
    bus.matrix_load = 1'b1;
    #1 chk1("rdy_on_load", bus.vtx_in_ready, 1'b0);
    @(negedge clk_in);
    bus.matrix_load = 1'b0;
    #1 chk1("rdy_on_commit", bus.vtx_in_ready, 1'b0);
    @(negedge clk_in);
    chk1("rdy_after_commit", bus.vtx_in_ready, 1'b1);
    chkm("m1_after_commit", bus.mvm_m1, m);
  endtask

  // Present a vertex; returns on the negedge following acceptance.
  task automatic issue(input vtx_t v);
    int n = 0;
    while (!bus.vtx_in_ready && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk1("accept_ready", bus.vtx_in_ready, 1'b1);
    bus.vtx_in       = v;
    bus.vtx_in_valid = 1'b1;
    @(negedge clk_in);
    bus.vtx_in_valid = 1'b0;
    chkv("v1_latched", bus.mvm_v1, v);
  endtask

  // Wait for done, check valid rises one cycle later with the result, and
  // (vtx_out_ready=1) drops after the handshake.
  task automatic collect(input vtx_t exp);
    int n = 0;
    while (!bus.mvm_done && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    chk1("done_seen", bus.mvm_done, 1'b1);
    chk1("valid_on_done", bus.vtx_out_valid, 1'b0);
    @(negedge clk_in);
    chk1("valid_after_done", bus.vtx_out_valid, 1'b1);
    chkv("vtx_out", bus.vtx_out, exp);
    @(negedge clk_in);
    chk1("valid_after_hs", bus.vtx_out_valid, 1'b0);
    chk1("idle_after_hs", bus.busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  rec_t tbl[3];
  mat_t ident, scale2, m2;
  vtx_t v1, v1x2, vsm;

  initial begin
    bus.matrix_in     = '0;
    bus.matrix_load   = 1'b0;
    bus.vtx_in        = '0;
    bus.vtx_in_valid  = 1'b0;
    bus.vtx_out_ready = 1'b1;

    ident  = mk_mat(mk_vtx(32'h00010000, 0, 0, 0), mk_vtx(0, 32'h00010000, 0, 0),
                    mk_vtx(0, 0, 32'h00010000, 0), mk_vtx(0, 0, 0, 32'h00010000));
    scale2 = mk_mat(mk_vtx(32'h00020000, 0, 0, 0), mk_vtx(0, 32'h00020000, 0, 0),
                    mk_vtx(0, 0, 32'h00020000, 0), mk_vtx(0, 0, 0, 32'h00020000));
    m2 = mk_mat(mk_vtx(32'hFFFF0000, 32'h00020000, 32'h00030000, 32'h00040000),
                mk_vtx(32'h00050000, 32'h00068000, 32'h0007C000, 32'h00080000),
                mk_vtx(32'h00090000, 32'h000A0000, 32'hFFE5C000, 32'h000C0000),
                mk_vtx(32'h000D0000, 32'h000E2000, 32'h000F0000, 32'h00100000));
    v1   = mk_vtx(32'hFFFC8000, 32'h00068000, 32'h0007C000, 32'h000C0000);
    v1x2 = mk_vtx(32'hFFF90000, 32'h000D0000, 32'h000F8000, 32'h00180000);
    vsm  = mk_vtx(32'h00010000, 32'h00020000, 32'h00030000, 32'h00010000);

    tbl[0] = '{m: ident,  v: v1,  lat: 5, exp: v1};
    tbl[1] = '{m: m2,     v: v1,  lat: 7,
               exp: mk_vtx(32'h0057C000, 32'h00B4D000, 32'hFFE61000, 32'h01629000)};
    tbl[2] = '{m: scale2, v: vsm, lat: 1,
               exp: mk_vtx(32'h00020000, 32'h00040000, 32'h00060000, 32'h00020000)};

    // reset state
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_valid", bus.vtx_out_valid, 1'b0);
    chk1("rst_err", bus.timeout_err, 1'b0);
    chk1("rst_start", bus.mvm_start, 1'b0);
    chk1("rst_ready", bus.vtx_in_ready, 1'b1);
    chkm("rst_m1", bus.mvm_m1, '0);
    chkv("rst_vout", bus.vtx_out, '0);

    // ISSUE held by multiplier busy, then output stall for 10 cycles
    load_matrix(ident);
    lat = 5;
    force_busy = 1'b1;
    bus.vtx_out_ready = 1'b0;
    issue(v1);
    chk1("busy_hold_start0", bus.mvm_start, 1'b0);
    @(negedge clk_in);
    chk1("busy_hold_start1", bus.mvm_start, 1'b0);
    chk1("busy_hold_busy", bus.busy, 1'b1);
    force_busy = 1'b0;
    #1 chk1("start_on_release", bus.mvm_start, 1'b1);
    begin
      int n = 0;
      while (!bus.mvm_done && n < 200) begin
        @(negedge clk_in);
        n++;
      end
      chk1("stall_done_seen", bus.mvm_done, 1'b1);
    end
    @(negedge clk_in);
    chk1("stall_valid0", bus.vtx_out_valid, 1'b1);
    bus.vtx_in       = vsm;
    bus.vtx_in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_in);
      chk1("stall_valid", bus.vtx_out_valid, 1'b1);
      chkv("stall_vout", bus.vtx_out, v1);
      chk1("stall_in_ready", bus.vtx_in_ready, 1'b0);
    end
    bus.vtx_in_valid  = 1'b0;
    bus.vtx_out_ready = 1'b1;
    @(negedge clk_in);
    chk1("stall_valid_drop", bus.vtx_out_valid, 1'b0);
`ifdef XFORM_SEQ_PERF_CNT_EN
    chkv("perf_stall", {96'd0, perf_stall_cycles}, {96'd0, 32'd10});
    chkv("perf_vtx", {96'd0, perf_vtx_count}, {96'd0, 32'd1});
`endif

    // table-driven transforms
    for (int k = 0; k < 3; k++) begin
      lat = tbl[k].lat;
      load_matrix(tbl[k].m);
      issue(tbl[k].v);
      chk1("tbl_start", bus.mvm_start, 1'b1);
      chkm("tbl_m1", bus.mvm_m1, tbl[k].m);
      collect(tbl[k].exp);
    end

    // matrix load during WAIT must not touch the in-flight vertex
    load_matrix(ident);
    lat = 8;
    issue(v1);
    chk1("lw_start", bus.mvm_start, 1'b1);
    @(negedge clk_in);
    bus.matrix_in   = scale2;
    bus.matrix_load = 1'b1;
    @(negedge clk_in);
    bus.matrix_load = 1'b0;
    chkm("lw_m1_held", bus.mvm_m1, ident);
    collect(v1);
    chk1("lw_idle_rdy0", bus.vtx_in_ready, 1'b0);
    @(negedge clk_in);
    chk1("lw_idle_rdy1", bus.vtx_in_ready, 1'b1);
    issue(v1);
    collect(v1x2);

    // watchdog timeout, late done ignored, then recovery
    never_done = 1'b1;
    lat = 10;
    issue(v1);
    chk1("to_start", bus.mvm_start, 1'b1);
    begin
      bit saw_valid = 1'b0;
      for (int k = 1; k <= 64; k++) begin
        @(negedge clk_in);
        if (bus.vtx_out_valid) saw_valid = 1'b1;
      end
      chk1("to_busy_last_wait", bus.busy, 1'b1);
      chk1("to_err_before", bus.timeout_err, 1'b0);
      @(negedge clk_in);
      chk1("to_busy_after", bus.busy, 1'b0);
      chk1("to_err_after", bus.timeout_err, 1'b1);
      chk1("to_no_valid", saw_valid, 1'b0);
    end
    inject_done = 1'b1;
    @(negedge clk_in);
    inject_done = 1'b0;
    @(negedge clk_in);
    chk1("late_done_valid", bus.vtx_out_valid, 1'b0);
    chk1("late_done_busy", bus.busy, 1'b0);
    never_done = 1'b0;
    lat = 3;
    issue(v1);
    collect(v1x2);
    chk1("to_err_sticky", bus.timeout_err, 1'b1);

    // reset mid-WAIT; the model's later done must be ignored
    lat = 20;
    issue(v1);
    repeat (3) @(negedge clk_in);
    chk1("rw_busy_before", bus.busy, 1'b1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk1("rw_busy", bus.busy, 1'b0);
    chk1("rw_valid", bus.vtx_out_valid, 1'b0);
    chk1("rw_err", bus.timeout_err, 1'b0);
    chk1("rw_start", bus.mvm_start, 1'b0);
    chk1("rw_ready", bus.vtx_in_ready, 1'b1);
    chkm("rw_m1", bus.mvm_m1, '0);
    chkv("rw_v1", bus.mvm_v1, '0);
    chkv("rw_vout", bus.vtx_out, '0);
    begin
      bit saw_done  = 1'b0;
      bit saw_valid = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk_in);
        if (bus.mvm_done) saw_done = 1'b1;
        if (bus.vtx_out_valid) saw_valid = 1'b1;
      end
      chk1("rw_model_done", saw_done, 1'b1);
      chk1("rw_no_valid", saw_valid, 1'b0);
      chk1("rw_idle", bus.busy, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
